bram_stream_reader: RTL and testbench
=====================================

# bram_stream_reader

Sequential read engine that sits directly downstream of the single-port `bram` block. It scans a programmed address range, absorbs the BRAM's one-cycle read latency, and presents the words as a valid/ready stream with a last-word marker. It owns the BRAM port while a job runs; the write side of the BRAM is held inactive by this block.

## Interface
- `RAM_WIDTH`, 8: data word width; matches the BRAM instance.
- `RAM_ADDR_BITS`, 8: BRAM address width; the address space is 2^`RAM_ADDR_BITS` words.
- `clock` input 1: sole clock; everything is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: job request; sampled only in IDLE.
- `abort` input 1: cancels the current job; takes priority over `start`.
- `base_addr` input `RAM_ADDR_BITS`: first address; sampled with `start`.
- `length` input `RAM_ADDR_BITS`+1: word count, 0..2^(`RAM_ADDR_BITS`+1)-1; sampled with `start`.
- `busy` output 1: high from the cycle after an accepted `start` until the job ends.
- `done` output 1: one-cycle pulse when a job completes normally.
- `ram_enable` output 1: BRAM enable.
- `write_enable` output 1: tied to 0.
- `address` output `RAM_ADDR_BITS`: BRAM address.
- `output_data` input `RAM_WIDTH`: BRAM read data, valid one cycle after `ram_enable`.
- `out_valid` output 1, `out_ready` input 1, `out_data` output `RAM_WIDTH`: downstream stream.
- `out_last` output 1: qualifies the final word of a job, or of each pass in loop mode.

## Operation
- States and transitions:
  - IDLE: on `start`, go to RUN.
  - RUN: issue reads; after the final issue, go to DRAIN.
  - DRAIN: wait for in-flight reads and the buffer to empty, then pulse `done` and return to IDLE.
- Each issue asserts `ram_enable` for one cycle with `address` = (`base_addr` + i) mod 2^`RAM_ADDR_BITS`, i = 0..`length`-1. Addresses wrap silently.
- The read data is captured into a 4-entry output FIFO in the cycle after the issue.
- Issue rule: `fill` + `inflight` < 4, where `inflight` (0..2) counts issued words not yet captured. This rule guarantees the FIFO never overflows, so no data is ever dropped.
- Stream rules:
  - A word transfers when `out_valid` and `out_ready` are both high.
  - `out_data` and `out_last` hold while `out_valid` is high and `out_ready` is low.
- `length` = 0: no reads are issued; go IDLE→DRAIN, `done` pulses 2 cycles after `start`, and no stream word is produced.
- `start` while busy: ignored.
- `abort` in RUN or DRAIN:
  - The FIFO is flushed and pending reads are discarded.
  - `out_valid` = 0 from the next cycle.
  - The state returns to IDLE with no `done`.
  - `abort` in IDLE has no effect.
- `reset` mid-job: same as `abort`, and all counters are cleared.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_enable`=0, `write_enable`=0, `address`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
- Cycle numbering, with `start` accepted in cycle 0:
  - Cycle 1: `busy`=1, first `ram_enable`.
  - Cycle 2: BRAM data is available.
  - Cycle 3: first `out_valid`. Start-to-first-word latency is 3 cycles.
- Throughput: 1 word/cycle sustained with `out_ready` held high.
- `done` is asserted in the cycle after the last word transfers; `busy` falls in that same cycle.

## Configuration
- `BRAM_READER_LOOP_EN` defined:
  - Adds input `loop` (1 bit), sampled with `start`.
  - If `loop`=1, after the last issue of a pass, issuing restarts at `base_addr` with no gap.
  - `out_last` marks the final word of every pass.
  - `done` never pulses; only `abort` or `reset` ends the job.
- `BRAM_READER_LOOP_EN` undefined: there is no `loop` port, and every job is single-pass.

## Structure
- Shared package holds:
  - state enum `reader_state_t` {IDLE, RUN, DRAIN};
  - constant `READER_FIFO_DEPTH` = 4;
  - constant `BRAM_READ_LATENCY` = 1.
- Sub-module `stream_fifo`: 4-entry, width `RAM_WIDTH`+1 (data plus last flag), with push/pop/fill and a synchronous flush.
- Remaining logic in the top: issue counter, in-flight counter, and the FSM.

## Test plan
- Functional BRAM model preloaded with mem[a]=a; `base_addr`=0x10, `length`=4, `out_ready`=1 → words 0x10..0x13 on cycles 3..6, `out_last` on 0x13, `done` on cycle 7.
- `base_addr`=0xFE, `length`=4 → addresses FE,FF,00,01 and data in that order.
- `length`=16 with `out_ready` toggling 1-in-3 → all 16 words in order, no loss or duplication, FIFO fill never exceeds 4, outputs held while stalled.
- `length`=0 → no `ram_enable`, no `out_valid`, `done` 2 cycles after `start`.
- `abort` after 5 of 10 words → `out_valid`=0 next cycle, no `done`; a new job with `base_addr`=0x40, `length`=2 yields 0x40, 0x41 only.
- With `BRAM_READER_LOOP_EN` defined, `loop`=1, `length`=3, base 0 → 0,1,2,0,1,2,… with `out_last` on every 2, no `done`; `abort` stops it.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader and its output FIFO.
// Loop mode is enabled by defining BRAM_READER_LOOP_EN.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } reader_state_t;

    localparam int READER_FIFO_DEPTH = 4;
    localparam int BRAM_READ_LATENCY = 1;
    localparam int FIFO_PTR_BITS     = $clog2(READER_FIFO_DEPTH);
    localparam int INFLIGHT_BITS     = $clog2(BRAM_READ_LATENCY + 2);

endpackage

// File: rtl/bram_stream_reader_stream_fifo.sv
// Small output FIFO holding {last, data}; synchronous flush empties it in one cycle.
module stream_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic [FIFO_PTR_BITS:0] fill_o,
    output logic                   empty_o
);

    logic [WIDTH-1:0]         mem_q [READER_FIFO_DEPTH];
    logic [FIFO_PTR_BITS-1:0] wr_ptr_q;
    logic [FIFO_PTR_BITS-1:0] rd_ptr_q;
    logic [FIFO_PTR_BITS:0]   fill_q;
    logic                     do_pop;

    assign do_pop     = pop_i && (fill_q != '0);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign fill_o     = fill_q;
    assign empty_o    = (fill_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_i && !do_pop)      fill_q <= fill_q + 1'b1;
            else if (!push_i && do_pop) fill_q <= fill_q - 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers and fill count alone define which entries are valid.
    always_ff @(posedge clock_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Scans an address range of a single-port BRAM and streams the words out with a last marker.
// Defining BRAM_READER_LOOP_EN adds the loop input for continuous multi-pass reading.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [RAM_ADDR_BITS-1:0] base_addr,
    input  logic [RAM_ADDR_BITS:0]   length,
`ifdef BRAM_READER_LOOP_EN
    input  logic                     loop,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     output_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_last
);

    reader_state_t              state_q, state_d;
    logic [RAM_ADDR_BITS-1:0]   base_q;
    logic [RAM_ADDR_BITS:0]     len_q;
    logic [RAM_ADDR_BITS:0]     cnt_q, cnt_d;
    logic [INFLIGHT_BITS-1:0]   inflight_q;
    logic                       pend_last_q;
    logic                       done_q, done_d;
    logic                       loop_q;

    logic                       accept, flush, issue, last_issue, capture, pop, room, drain_clear;
    logic [FIFO_PTR_BITS:0]     fifo_fill;
    logic [FIFO_PTR_BITS+1:0]   occupancy;
    logic                       fifo_empty;
    logic [RAM_WIDTH:0]         fifo_rd_data;

    assign accept     = (state_q == IDLE) && start && !abort;
    assign flush      = (state_q != IDLE) && abort;
    assign capture    = (inflight_q != '0);
    assign last_issue = (cnt_q == len_q - 1'b1);
    assign pop        = out_valid && out_ready;

    // Words already issued but not yet captured still need a FIFO slot when they land.
    assign occupancy   = {1'b0, fifo_fill} + (FIFO_PTR_BITS + 2)'(inflight_q);
    assign room        = occupancy < (FIFO_PTR_BITS + 2)'(READER_FIFO_DEPTH);
    assign drain_clear = (inflight_q == '0) &&
                         (fifo_empty || (fifo_fill == (FIFO_PTR_BITS + 1)'(1) && pop));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            inflight_q  <= '0;
            pend_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (accept) begin
                base_q <= base_addr;
                len_q  <= length;
            end
            if (flush)                  inflight_q <= '0;
            else if (issue && !capture) inflight_q <= inflight_q + 1'b1;
            else if (!issue && capture) inflight_q <= inflight_q - 1'b1;
            if (issue) pend_last_q <= last_issue;
        end
    end

`ifdef BRAM_READER_LOOP_EN
    always_ff @(posedge clock) begin
        if (reset)       loop_q <= 1'b0;
        else if (accept) loop_q <= loop;
    end
`else
    assign loop_q = 1'b0;
`endif

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (length == '0) ? DRAIN : RUN;
            RUN: begin
                if (abort)                                  state_d = IDLE;
                else if (issue && last_issue && !loop_q)    state_d = DRAIN;
            end
            DRAIN: begin
                if (abort)                                  state_d = IDLE;
                else if (drain_clear && !loop_q)            state_d = IDLE;
            end
            default:                                        state_d = IDLE;
        endcase
    end

    always_comb begin
        issue  = (state_q == RUN) && !abort && room;
        busy   = (state_q != IDLE);
        done_d = (state_q == DRAIN) && !abort && drain_clear && !loop_q;
        cnt_d  = cnt_q;
        if (accept)     cnt_d = '0;
        else if (issue) cnt_d = last_issue ? '0 : cnt_q + 1'b1;
    end

    stream_fifo #(
        .WIDTH(RAM_WIDTH + 1)
    ) u_fifo (
        .clock_i     (clock),
        .reset_i     (reset),
        .flush_i     (flush),
        .push_i      (capture && !flush),
        .push_data_i ({pend_last_q, output_data}),
        .pop_i       (pop),
        .pop_data_o  (fifo_rd_data),
        .fill_o      (fifo_fill),
        .empty_o     (fifo_empty)
    );

    assign ram_enable   = issue;
    assign write_enable = 1'b0;
    assign address      = base_q + cnt_q[RAM_ADDR_BITS-1:0];
    assign done         = done_q;
    assign out_valid    = !fifo_empty;
    assign out_data     = out_valid ? fifo_rd_data[RAM_WIDTH-1:0] : '0;
    assign out_last     = out_valid && fifo_rd_data[RAM_WIDTH];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: BRAM model with mem[a]=a, an arithmetic stream model
// checked every cycle, and directed jobs with hand-computed expectations.
module tb_bram_stream_reader;

    localparam int W  = 8;
    localparam int AB = 8;

    logic          clock = 1'b0;
    logic          reset, start, abort, out_ready;
    logic [AB-1:0] base_addr;
    logic [AB:0]   length;
`ifdef BRAM_READER_LOOP_EN
    logic          loop;
`endif
    logic          busy, done, ram_enable, write_enable, out_valid, out_last;
    logic [AB-1:0] address;
    logic [W-1:0]  output_data = '0;
    logic [W-1:0]  out_data;

    logic [W-1:0]  mem [1 << AB];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ready_mode = 0;

    // model state
    bit            mon_en = 0;
    bit            in_job, live, issuing, m_loop, prev_stall;
    logic [AB-1:0] m_base;
    int            m_len, iss_idx, xfer_idx, done_due, start_cyc, first_valid_cyc, done_cyc;
    int            en_count, valid_count;
    logic [W-1:0]  prev_data;
    logic          prev_last;
    logic [W-1:0]  got_q [$];

    bram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .length       (length),
`ifdef BRAM_READER_LOOP_EN
        .loop         (loop),
`endif
        .busy         (busy),
        .done         (done),
        .ram_enable   (ram_enable),
        .write_enable (write_enable),
        .address      (address),
        .output_data  (output_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (ram_enable) output_data <= mem[address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] exp_word(input int idx);
        return m_base + W'(idx % m_len);
    endfunction

    task automatic model_clear();
        in_job = 0; live = 0; issuing = 0; prev_stall = 0; done_due = -1;
        iss_idx = 0; xfer_idx = 0; m_len = 1;
    endtask

    // Stream model: every cycle, compare DUT outputs against what the job parameters imply.
    always @(negedge clock) if (mon_en) begin
        if (cyc == done_due) in_job = 0;
        check("busy", 32'(busy), 32'(in_job));
        check("done", 32'(done), 32'(cyc == done_due));
        check("write_enable", 32'(write_enable), 32'd0);
        if (done) done_cyc = cyc;

        if (!issuing) check("ram_enable_idle", 32'(ram_enable), 32'd0);
        else if (ram_enable) begin
            en_count++;
            check("address", 32'(address), 32'(exp_word(iss_idx)));
            iss_idx++;
            check("fifo_bound", 32'((iss_idx - xfer_idx) > 4), 32'd0);
            if (!m_loop && iss_idx == m_len) issuing = 0;
        end

        if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(prev_data));
            check("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (!live) check("out_valid_idle", 32'(out_valid), 32'd0);
        else if (out_valid) begin
            valid_count++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            check("out_data", 32'(out_data), 32'(exp_word(xfer_idx)));
            check("out_last", 32'(out_last), 32'((xfer_idx % m_len) == m_len - 1));
            if (out_ready) begin
                got_q.push_back(out_data);
                xfer_idx++;
                if (!m_loop && xfer_idx == m_len) begin
                    live = 0;
                    done_due = cyc + 1;
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;

        if (abort && in_job) begin
            in_job = 0; live = 0; issuing = 0; prev_stall = 0; done_due = -1;
        end else if (start && !abort && !in_job) begin
            in_job = 1;
            m_base = base_addr;
            m_len  = int'(length);
`ifdef BRAM_READER_LOOP_EN
            m_loop = loop;
`else
            m_loop = 0;
`endif
            live = (m_len > 0); issuing = (m_len > 0);
            iss_idx = 0; xfer_idx = 0; en_count = 0; valid_count = 0;
            start_cyc = cyc; first_valid_cyc = -1; done_cyc = -1;
            done_due = (m_len == 0) ? cyc + 2 : -1;
            if (m_len == 0) m_len = 1;
            got_q.delete();
        end
    end

    initial forever begin
        @(posedge clock);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(1));
        endcase
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_job(input logic [AB-1:0] b, input int l, input bit lp);
        base_addr = b;
        length    = (AB + 1)'(l);
`ifdef BRAM_READER_LOOP_EN
        loop      = lp;
`else
        if (lp) $display("loop request ignored: loop mode not built");
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check({"timeout_", name}, 32'(busy), 32'd0);
        tick();
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ram_enable"}, 32'(ram_enable), 32'd0);
        check({tag, "_write_enable"}, 32'(write_enable), 32'd0);
        check({tag, "_address"}, 32'(address), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AB); i++) mem[i] = W'(i);
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
`ifdef BRAM_READER_LOOP_EN
        loop = 1'b0;
`endif
        model_clear();
        m_loop = 0; m_base = '0; en_count = 0; valid_count = 0;
        start_cyc = 0; first_valid_cyc = -1; done_cyc = -1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_values("reset");
        mon_en = 1;

        // basic job: words 0x10..0x13 on cycles 3..6, done on cycle 7
        ready_mode = 0;
        start_job(8'h10, 4, 0);
        wait_idle("basic");
        check("basic_first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd3);
        check("basic_done_latency", 32'(done_cyc - start_cyc), 32'd7);
        check("basic_enables", 32'(en_count), 32'd4);
        check("basic_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) check("basic_word3", 32'(got_q[3]), 32'h13);

        // address wrap
        start_job(8'hFE, 4, 0);
        wait_idle("wrap");
        check("wrap_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            check("wrap_w0", 32'(got_q[0]), 32'hFE);
            check("wrap_w1", 32'(got_q[1]), 32'hFF);
            check("wrap_w2", 32'(got_q[2]), 32'h00);
            check("wrap_w3", 32'(got_q[3]), 32'h01);
        end

        // backpressure 1-in-3, plus an ignored start while busy
        ready_mode = 1;
        start_job(8'h20, 16, 0);
        repeat (6) tick();
        base_addr = 8'h99; length = 9'd5; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("stall");
        check("stall_count", 32'(got_q.size()), 32'd16);
        if (got_q.size() == 16) begin
            check("stall_w0", 32'(got_q[0]), 32'h20);
            check("stall_w15", 32'(got_q[15]), 32'h2F);
        end

        // zero length
        ready_mode = 0;
        start_job(8'h33, 0, 0);
        wait_idle("zero");
        check("zero_enables", 32'(en_count), 32'd0);
        check("zero_valids", 32'(valid_count), 32'd0);
        check("zero_done_latency", 32'(done_cyc - start_cyc), 32'd2);

        // abort after 5 of 10, then a fresh short job
        begin
            int n = 0;
            start_job(8'h80, 10, 0);
            while (got_q.size() < 5 && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100) check("abort_wait_timeout", 32'(got_q.size()), 32'd5);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_valid_low", 32'(out_valid), 32'd0);
            repeat (8) tick();
            check("abort_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
            check("abort_busy_low", 32'(busy), 32'd0);
        end
        start_job(8'h40, 2, 0);
        wait_idle("after_abort");
        check("after_abort_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("after_abort_w0", 32'(got_q[0]), 32'h40);
            check("after_abort_w1", 32'(got_q[1]), 32'h41);
        end

        // random backpressure across the wrap
        ready_mode = 2;
        start_job(8'hF0, 24, 0);
        wait_idle("random");
        check("random_count", 32'(got_q.size()), 32'd24);

`ifdef BRAM_READER_LOOP_EN
        ready_mode = 0;
        start_job(8'h00, 3, 1);
        repeat (20) tick();
        check("loop_busy", 32'(busy), 32'd1);
        check("loop_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
        if (got_q.size() >= 7) begin
            check("loop_w2", 32'(got_q[2]), 32'h02);
            check("loop_w3", 32'(got_q[3]), 32'h00);
            check("loop_w6", 32'(got_q[6]), 32'h00);
        end else check("loop_count", 32'(got_q.size()), 32'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        check("loop_abort_busy", 32'(busy), 32'd0);
`endif

        // reset in the middle of a job
        ready_mode = 0;
        start_job(8'h30, 8, 0);
        repeat (4) tick();
        mon_en = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        check_reset_values("midreset");
        mon_en = 1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
